sd_decimator: RTL
=================

# sd_decimator

Bitstream decoder for the 1-bit sigma-delta DAC path. It counts the ones in consecutive, non-overlapping windows of 2^LOG_WIN accepted samples and presents the count as an unsigned LOG_WIN-bit value, saturated at full scale. It sits on the receive/monitor side of the modulator. It recovers the digital code from the density stream for loopback checking and for the measurement channel.

## Interface

Parameters:
- LOG_WIN, default 4: window length is 2^LOG_WIN samples; output width is LOG_WIN bits; legal range 2..8.

Ports:
- clk, input, 1: single clock; all logic updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- bit_in, input, 1: sigma-delta bitstream sample.
- bit_en, input, 1: qualifies bit_in; a sample is accepted only on edges where bit_en=1.
- restart, input, 1: synchronous window restart; discards the partial window.
- dout, output, LOG_WIN: decoded window value; holds between updates.
- dout_valid, output, 1: one-cycle pulse when dout has just been updated.
- sat, output, 1: set when the window that produced the current dout contained 2^LOG_WIN ones; holds with dout.

## Operation

- State:
  - sample counter `cnt`, LOG_WIN bits, range 0..2^LOG_WIN-1.
  - ones accumulator `acc`, LOG_WIN+1 bits.
  - output registers dout and sat.
  - pulse register dout_valid.
- Accept on bit_en=1 and restart=0 and rst=0:
  - If cnt < 2^LOG_WIN-1: acc <= acc + bit_in, cnt <= cnt+1.
  - If cnt = 2^LOG_WIN-1 (last sample): total = acc + bit_in, computed at LOG_WIN+1 bits.
    - dout <= (total = 2^LOG_WIN) ? 2^LOG_WIN-1 : total[LOG_WIN-1:0].
    - sat <= (total = 2^LOG_WIN).
    - dout_valid <= 1.
    - acc <= 0 and cnt <= 0 (counter wraps).
- When bit_en=0: cnt and acc hold, and no sample is counted.
- restart=1: cnt <= 0 and acc <= 0. Any bit_en sample on that edge is discarded, and no dout_valid is produced. dout and sat hold their last values.
- Priority, highest first: rst, then restart, then sample accept.
- Windows never overlap; every accepted sample belongs to exactly one window.
- For a first-order modulator fed a constant code k with its integrator aligned to the window start, the decoded value is exactly k (0..2^LOG_WIN-1).

## Timing

- Reset (rst=1 at an edge):
  - dout=0, sat=0, dout_valid=0.
  - cnt=0, acc=0.
  - The first window starts with the first accepted sample after rst deasserts.
- Latency: dout, sat and dout_valid are all registered at the same edge that accepts the last sample of a window. They are visible in the following cycle.
- dout_valid is high for exactly one cycle per completed window.
  - dout_valid is 0 on every edge that is not a window completion, including when bit_en=0.
  - Minimum spacing between pulses is 2^LOG_WIN cycles, reached with bit_en held at 1.
- Back-to-back windows: the edge after a completion may accept the first sample of the next window, with no dead cycle.
- Reset or restart mid-window: the partial count is lost, and no output or pulse is generated for it.
- restart on the same edge as a would-be last sample: restart wins, with no pulse and dout unchanged.
- bit_in is ignored whenever bit_en=0; X on bit_in with bit_en=0 must not propagate.

## Test plan

- Reset: assert rst for 3 cycles with bit_en=1 and bit_in=1 -> dout=0, sat=0, dout_valid=0 throughout. The first pulse appears exactly 16 accepted samples after rst drops (LOG_WIN=4).
- Extremes:
  - 16 zeros -> dout=0, sat=0, one dout_valid pulse.
  - 16 ones -> dout=15, sat=1.
  - Next window of 15 ones then one zero -> dout=15, sat=0.
- Pattern: alternating 1,0 with bit_en=1 continuously -> dout=8 on every pulse, with pulses exactly 16 cycles apart and no dead cycles.
- Gaps: 16 samples of pattern 1,1,0,0 with bit_en toggling randomly -> dout=8, with the pulse on the edge of the 16th accepted sample only.
- Restart:
  - 10 ones, then restart=1 with bit_en=1 and bit_in=1, then 16 samples containing 3 ones -> single pulse, dout=3.
  - restart coincident with the 16th sample -> no pulse, dout holds its previous value.
- Loopback: first-order modulator with constant code k=5, then k=0, 1, 14, 15, windows aligned -> dout equals k for each window, sat=0; rst mid-window -> no pulse for that partial window.

Source files
------------

// File: rtl/sd_decimator_if.sv
// Sample-stream and decoded-value bundle for sd_decimator.
// The master drives the bitstream side; the slave returns the window result.
interface sd_decimator_if #(
  parameter int LOG_WIN = 4
);
  logic               bit_in;
  logic               bit_en;
  logic               restart;
  logic [LOG_WIN-1:0] dout;
  logic               dout_valid;
  logic               sat;

  modport master (
    output bit_in, bit_en, restart,
    input  dout, dout_valid, sat
  );

  modport slave (
    input  bit_in, bit_en, restart,
    output dout, dout_valid, sat
  );
endinterface

// File: rtl/sd_decimator.sv
// Counts ones over non-overlapping windows of 2^LOG_WIN accepted sigma-delta samples
// and reports the count, saturated to LOG_WIN bits, with a one-cycle valid pulse.
module sd_decimator #(
  parameter int LOG_WIN = 4
) (
  input logic           clk,
  input logic           rst,
  sd_decimator_if.slave bus
);
  localparam logic [LOG_WIN-1:0] CNT_LAST = {LOG_WIN{1'b1}};
  localparam logic [LOG_WIN:0]   FULL     = {1'b1, {LOG_WIN{1'b0}}};

  logic [LOG_WIN-1:0] r_cnt;
  logic [LOG_WIN:0]   r_acc;
  logic [LOG_WIN-1:0] r_dout;
  logic               r_sat;
  logic               r_dout_valid;

  logic               w_bit;
  logic [LOG_WIN:0]   w_total;
  logic               w_full;
  logic               w_last;

  // Gating with bit_en keeps an undefined bit_in out of the accumulator.
  assign w_bit   = bus.bit_en & bus.bit_in;
  assign w_total = r_acc + {{LOG_WIN{1'b0}}, w_bit};
  assign w_full  = (w_total == FULL);
  assign w_last  = (r_cnt == CNT_LAST);

  // Window counter, ones accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= {LOG_WIN{1'b0}};
      r_acc        <= {(LOG_WIN+1){1'b0}};
      r_dout       <= {LOG_WIN{1'b0}};
      r_sat        <= 1'b0;
      r_dout_valid <= 1'b0;
    end else if (bus.restart) begin
      r_cnt        <= {LOG_WIN{1'b0}};
      r_acc        <= {(LOG_WIN+1){1'b0}};
      r_dout_valid <= 1'b0;
    end else if (bus.bit_en) begin
      if (w_last) begin
        r_dout       <= w_full ? CNT_LAST : w_total[LOG_WIN-1:0];
        r_sat        <= w_full;
        r_dout_valid <= 1'b1;
        r_cnt        <= {LOG_WIN{1'b0}};
        r_acc        <= {(LOG_WIN+1){1'b0}};
      end else begin
        r_acc        <= w_total;
        r_cnt        <= r_cnt + {{(LOG_WIN-1){1'b0}}, 1'b1};
        r_dout_valid <= 1'b0;
      end
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.sat        = r_sat;
  assign bus.dout_valid = r_dout_valid;
endmodule
